// File: rtl/gray_accum_pkg.sv
// gray_accum_pkg: shared types and helpers for the Gray-code accumulator.
//   accum_state_e : controller state encoding (IDLE, ACCUM, DONE)
//   CNT_W         : width of the beat counter and out_count
//   bin2gray      : binary-to-Gray conversion; callers cast the result to their width
package gray_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } accum_state_e;

  localparam int CNT_W = 8;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_accum_if.sv
// gray_accum_if: input and output handshakes of gray_accum.
//   in_valid/in_ready/in_gray : Gray-coded sums from the upstream adder
//   flush                     : single-cycle pulse closing the current result early
//   out_valid/out_ready       : result handshake
//   out_gray/out_count/out_ovf: Gray-coded total, beat count, overflow flag
// Modports: master = producer/consumer side, slave = accumulator side.
interface gray_accum_if
  import gray_accum_pkg::*;
#(
  parameter int IN_W  = 5,
  parameter int ACC_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_gray;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_gray;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_gray, flush, out_ready,
    input  in_ready, out_valid, out_gray, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_gray, flush, out_ready,
    output in_ready, out_valid, out_gray, out_count, out_ovf
  );
endinterface

// File: rtl/gray_accum_gray_to_bin.sv
// gray_to_bin_n: combinational Gray-to-binary converter of width W.
//   gray : Gray-coded input
//   bin  : binary output; bit i is the XOR of gray[W-1:i]
module gray_to_bin_n #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/gray_accum.sv
// gray_accum: accumulates NUM_TERMS Gray-coded sums (fewer on flush) and
// presents the total in Gray code with a beat count and overflow flag.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; discards any partial or pending result
//   bus   : gray_accum_if.slave carrying both handshakes, flush and result fields
// Build option GRAY_ACCUM_SAT_EN: saturate at 2^ACC_W-1 on overflow instead of wrapping.
module gray_accum
  import gray_accum_pkg::*;
#(
  parameter int IN_W      = 5,
  parameter int ACC_W     = 8,
  parameter int NUM_TERMS = 4
) (
  input logic          clk,
  input logic          rst_n,
  gray_accum_if.slave  bus
);

  accum_state_e     state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] count, cnt_nxt;
  logic             ovf, ovf_nxt;
  logic             alive;
  logic             accept;
  logic [IN_W-1:0]  bin;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] og_q;
  logic [CNT_W-1:0] oc_q;
  logic             oo_q;

  // With saturation, an accumulator already at the maximum either stays there
  // (zero term) or carries again, so no separate hold flag is needed.
  function automatic logic [ACC_W-1:0] sat_or_wrap(input logic [ACC_W:0] s);
`ifdef GRAY_ACCUM_SAT_EN
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
    return s[ACC_W-1:0];
`endif
  endfunction

  gray_to_bin_n #(.W(IN_W)) u_g2b (
    .gray (bus.in_gray),
    .bin  (bin)
  );

  assign accept = bus.in_valid && bus.in_ready;
  assign sum    = {1'b0, acc} + {{(ACC_W + 1 - IN_W){1'b0}}, bin};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = count;
    ovf_nxt   = ovf;
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_nxt = sat_or_wrap(sum);
          ovf_nxt = ovf | sum[ACC_W];
          cnt_nxt = count + 1'b1;
        end
        // Flush counts a same-cycle accept, so cnt_nxt is the deciding value.
        if (accept && (cnt_nxt == CNT_W'(NUM_TERMS))) state_nxt = DONE;
        else if (bus.flush && (cnt_nxt != '0))        state_nxt = DONE;
        else if (accept)                              state_nxt = ACCUM;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs derived from state; alive keeps in_ready low until the first edge after reset
  always_comb begin
    bus.in_ready  = alive && (state != DONE);
    bus.out_valid = (state == DONE);
  end

  // Accumulator and registered result fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      alive <= 1'b0;
      og_q  <= '0;
      oc_q  <= '0;
      oo_q  <= 1'b0;
    end else begin
      acc   <= acc_nxt;
      count <= cnt_nxt;
      ovf   <= ovf_nxt;
      alive <= 1'b1;
      if ((state != DONE) && (state_nxt == DONE)) begin
        og_q <= ACC_W'(bin2gray(32'(acc_nxt)));
        oc_q <= cnt_nxt;
        oo_q <= ovf_nxt;
      end else if ((state == DONE) && (state_nxt != DONE)) begin
        og_q <= '0;
        oc_q <= '0;
        oo_q <= 1'b0;
      end
    end
  end

  assign bus.out_gray  = og_q;
  assign bus.out_count = oc_q;
  assign bus.out_ovf   = oo_q;

endmodule

// File: tb/tb_gray_accum.sv
// tb_gray_accum: directed bench for gray_accum (ACC_W=8 instance plus an ACC_W=6 instance).
module tb_gray_accum;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  gray_accum_if #(.IN_W(5), .ACC_W(8)) bus ();
  gray_accum_if #(.IN_W(5), .ACC_W(6)) bus6 ();

  gray_accum #(.IN_W(5), .ACC_W(8), .NUM_TERMS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  gray_accum #(.IN_W(5), .ACC_W(6), .NUM_TERMS(4)) dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [4:0] g);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_gray  = g;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $error("FAIL beat_wait observed=in_ready_low expected=in_ready_high");
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_gray    = '0;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b0;
    bus6.in_valid  = 1'b0;
    bus6.in_gray   = '0;
    bus6.flush     = 1'b0;
    bus6.out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_gray", 32'(bus.out_gray), 0);
    chk("rst_out_count", 32'(bus.out_count), 0);
    chk("rst_out_ovf", 32'(bus.out_ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(bus.in_ready), 1);

    // Four beats of binary 4 with out_ready high
    bus.out_ready = 1'b1;
    beat(5'b00110); beat(5'b00110); beat(5'b00110);
    chk("t1_valid_before", 32'(bus.out_valid), 0);
    beat(5'b00110);
    chk("t1_valid", 32'(bus.out_valid), 1);
    chk("t1_gray", 32'(bus.out_gray), 32'h18);
    chk("t1_count", 32'(bus.out_count), 4);
    chk("t1_ovf", 32'(bus.out_ovf), 0);
    chk("t1_in_ready_done", 32'(bus.in_ready), 0);
    tick();
    chk("t1_valid_after", 32'(bus.out_valid), 0);
    chk("t1_gray_after", 32'(bus.out_gray), 0);
    chk("t1_count_after", 32'(bus.out_count), 0);
    chk("t1_in_ready_after", 32'(bus.in_ready), 1);

    // Four beats of binary 30, result held one extra cycle
    bus.out_ready = 1'b0;
    repeat (4) beat(5'h11);
    chk("t2_gray", 32'(bus.out_gray), 32'h44);
    chk("t2_count", 32'(bus.out_count), 4);
    chk("t2_ovf", 32'(bus.out_ovf), 0);
    tick();
    chk("t2_valid_hold", 32'(bus.out_valid), 1);
    chk("t2_gray_hold", 32'(bus.out_gray), 32'h44);
    bus.out_ready = 1'b1;
    tick();
    chk("t2_valid_after", 32'(bus.out_valid), 0);

    // Two beats then flush; then flush with nothing accumulated
    beat(5'b00110); beat(5'b00110);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("t3_valid", 32'(bus.out_valid), 1);
    chk("t3_gray", 32'(bus.out_gray), 32'h0C);
    chk("t3_count", 32'(bus.out_count), 2);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("t3_empty_flush_valid", 32'(bus.out_valid), 0);
    tick();
    chk("t3_empty_flush_valid2", 32'(bus.out_valid), 0);

    // Backpressure with a held input beat
    bus.out_ready = 1'b0;
    repeat (4) beat(5'b00110);
    bus.in_valid = 1'b1;
    bus.in_gray  = 5'b00110;
    for (int i = 0; i < 5; i++) begin
      chk("t4_in_ready_bp", 32'(bus.in_ready), 0);
      chk("t4_valid_bp", 32'(bus.out_valid), 1);
      chk("t4_gray_bp", 32'(bus.out_gray), 32'h18);
      chk("t4_count_bp", 32'(bus.out_count), 4);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("t4_valid_released", 32'(bus.out_valid), 0);
    chk("t4_in_ready_released", 32'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    chk("t4_valid_after_held", 32'(bus.out_valid), 0);
    repeat (3) beat(5'b00110);
    chk("t4_held_valid", 32'(bus.out_valid), 1);
    chk("t4_held_count", 32'(bus.out_count), 4);
    chk("t4_held_gray", 32'(bus.out_gray), 32'h18);
    tick();

    // Flush coinciding with the third accept
    beat(5'b00110); beat(5'b00110);
    bus.flush = 1'b1;
    beat(5'b00110);
    bus.flush = 1'b0;
    chk("t5_valid", 32'(bus.out_valid), 1);
    chk("t5_count", 32'(bus.out_count), 3);
    chk("t5_gray", 32'(bus.out_gray), 32'h0A);
    tick();

    // Reset mid-accumulation, then a fresh result
    beat(5'b00110); beat(5'b00110);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_in_ready", 32'(bus.in_ready), 0);
    chk("t6_rst_valid", 32'(bus.out_valid), 0);
    chk("t6_rst_gray", 32'(bus.out_gray), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t6_in_ready", 32'(bus.in_ready), 1);
    repeat (4) beat(5'h11);
    chk("t6_fresh_gray", 32'(bus.out_gray), 32'h44);
    chk("t6_fresh_count", 32'(bus.out_count), 4);
    chk("t6_fresh_ovf", 32'(bus.out_ovf), 0);
    tick();

    // Reset while a result is pending
    bus.out_ready = 1'b0;
    repeat (4) beat(5'b00110);
    chk("t7_valid_pending", 32'(bus.out_valid), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", 32'(bus.out_valid), 0);
    chk("t7_rst_gray", 32'(bus.out_gray), 0);
    chk("t7_rst_count", 32'(bus.out_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus.out_ready = 1'b1;

    // Narrow accumulator: 4 x 30 overflows 6 bits
    bus6.out_ready = 1'b0;
    bus6.in_valid  = 1'b1;
    bus6.in_gray   = 5'h11;
    repeat (4) tick();
    bus6.in_valid  = 1'b0;
    chk("t8_valid", 32'(bus6.out_valid), 1);
    chk("t8_count", 32'(bus6.out_count), 4);
    chk("t8_ovf", 32'(bus6.out_ovf), 1);
`ifdef GRAY_ACCUM_SAT_EN
    chk("t8_gray_sat", 32'(bus6.out_gray), 32'h20);
`else
    chk("t8_gray_wrap", 32'(bus6.out_gray), 32'h24);
`endif
    bus6.out_ready = 1'b1;
    tick();
    chk("t8_valid_after", 32'(bus6.out_valid), 0);
    chk("t8_ovf_after", 32'(bus6.out_ovf), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
